// File: rtl/motor_pwm_generator_pkg.sv
// motor_pwm_generator_pkg: rate width, FSM states and default timing shared by the motor PWM block.
package motor_pwm_generator_pkg;
  localparam int RATE_W           = 8;
  localparam int DEF_SYS_CLK_HZ   = 38000000;
  localparam int DEF_PWM_FRAME_HZ = 400;
  localparam int DEF_MIN_PULSE_US = 1000;
  localparam int DEF_MAX_PULSE_US = 2000;
  typedef enum logic [1:0] {S_LATCH, S_MIN, S_MOD, S_LOW} pwm_state_e;
  function automatic int us_to_cyc(input int hz, input int us);
    return hz / 1000000 * us;
  endfunction
endpackage

// File: rtl/motor_pwm_channel.sv
// motor_pwm_channel: one ESC output; holds its frame rate and drops when the shared step reaches it.
module motor_pwm_channel
  import motor_pwm_generator_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              set_high,
  input  logic              modulate,
  input  logic [RATE_W-1:0] rate,
  input  logic [RATE_W-1:0] step_idx,
  output logic              pwm
);
  logic [RATE_W-1:0] rate_q;
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      rate_q <= '0;
      pwm    <= 1'b0;
    end else begin
      if (latch) rate_q <= rate;
      pwm <= set_high | (pwm & modulate & (step_idx != rate_q));
    end
endmodule

// File: rtl/motor_pwm_generator.sv
// motor_pwm_generator: four-channel ESC servo PWM with per-frame rate sampling and a frame_sync strobe.
// Defining MOTOR_PWM_ARM_EN adds the armed input; disarmed frames latch every rate as 0.
module motor_pwm_generator
  import motor_pwm_generator_pkg::*;
#(
  parameter int SYS_CLK_HZ   = DEF_SYS_CLK_HZ,
  parameter int PWM_FRAME_HZ = DEF_PWM_FRAME_HZ,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [RATE_W-1:0] motor_1_rate,
  input  logic [RATE_W-1:0] motor_2_rate,
  input  logic [RATE_W-1:0] motor_3_rate,
  input  logic [RATE_W-1:0] motor_4_rate,
`ifdef MOTOR_PWM_ARM_EN
  input  logic              armed,
`endif
  output logic              motor_1_pwm,
  output logic              motor_2_pwm,
  output logic              motor_3_pwm,
  output logic              motor_4_pwm,
  output logic              frame_sync
);
  localparam int FRAME_CYC = SYS_CLK_HZ / PWM_FRAME_HZ;
  localparam int MIN_CYC   = us_to_cyc(SYS_CLK_HZ, MIN_PULSE_US);
  localparam int STEP_CYC  = (us_to_cyc(SYS_CLK_HZ, MAX_PULSE_US) - MIN_CYC) / 256;
  localparam int FW        = $clog2(FRAME_CYC);
  localparam int PW        = $clog2(STEP_CYC + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);
  localparam logic [FW-1:0] MIN_LAST   = FW'(MIN_CYC);
  localparam logic [PW-1:0] STEP_LAST  = PW'(STEP_CYC - 1);
  if (STEP_CYC < 1 || MIN_CYC + 255 * STEP_CYC >= FRAME_CYC - 1) begin : g_guard
    $error("motor_pwm_generator: pulse range does not fit in the PWM frame");
  end
  pwm_state_e        state;
  logic [FW-1:0]     frame_cnt;
  logic [PW-1:0]     presc;
  logic [RATE_W-1:0] step_idx;
  logic              wrap;
  logic              step_end;
  logic              arm;
  logic [RATE_W-1:0] rate [4];
  logic [3:0]        pwm;
  assign wrap     = frame_cnt == FRAME_LAST;
  assign step_end = presc == STEP_LAST;
  assign rate     = '{motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate};
  assign {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm} = pwm;
`ifdef MOTOR_PWM_ARM_EN
  assign arm = armed;
`else
  assign arm = 1'b1;
`endif
  // LATCH always sits at frame_cnt == 0, so S_MIN ends when frame_cnt reaches MIN_CYC
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      state      <= S_LATCH;
      frame_cnt  <= '0;
      presc      <= '0;
      step_idx   <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_cnt  <= wrap ? '0 : frame_cnt + 1'b1;
      frame_sync <= state == S_LATCH;
      case (state)
        S_LATCH: state <= S_MIN;
        S_MIN: if (frame_cnt == MIN_LAST) begin
          state    <= S_MOD;
          presc    <= '0;
          step_idx <= '0;
        end
        S_MOD: begin
          presc    <= step_end ? '0 : presc + 1'b1;
          step_idx <= step_end ? step_idx + 1'b1 : step_idx;
          if (wrap) state <= S_LATCH;
          else if (step_end && step_idx == '1) state <= S_LOW;
        end
        default: if (wrap) state <= S_LATCH;
      endcase
    end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    motor_pwm_channel u_ch (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .latch    (state == S_LATCH),
      .set_high (state == S_MIN),
      .modulate (state == S_MOD),
      .rate     (arm ? rate[i] : '0),
      .step_idx (step_idx),
      .pwm      (pwm[i])
    );
  end
endmodule

// File: tb/tb_motor_pwm_generator.sv
// tb_motor_pwm_generator: random per-frame rates against a pulse-width model, scoreboarded per frame.
module tb_motor_pwm_generator;
  localparam int SYS_HZ   = 1000000;
  localparam int FRAME_HZ = 1800;
  localparam int MIN_US   = 10;
  localparam int MAX_US   = 530;
  localparam int FRAME    = SYS_HZ / FRAME_HZ;
  localparam int MIN_W    = SYS_HZ / 1000000 * MIN_US;
  localparam int STEP     = (SYS_HZ / 1000000 * MAX_US - MIN_W) / 256;
  localparam int NF1      = 30;
  localparam int NF2      = 12;

  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0;
  logic p1, p2, p3, p4, fs;
`ifdef MOTOR_PWM_ARM_EN
  logic armed = 1'b1;
`endif
  int errors = 0;
  int checks = 0;
  int frames_done = 0;
  int exp_q[$];

  always #5 sys_clk = ~sys_clk;

  motor_pwm_generator #(
    .SYS_CLK_HZ(SYS_HZ), .PWM_FRAME_HZ(FRAME_HZ), .MIN_PULSE_US(MIN_US), .MAX_PULSE_US(MAX_US)
  ) dut (
    .sys_clk(sys_clk), .reset(reset),
    .motor_1_rate(r1), .motor_2_rate(r2), .motor_3_rate(r3), .motor_4_rate(r4),
`ifdef MOTOR_PWM_ARM_EN
    .armed(armed),
`endif
    .motor_1_pwm(p1), .motor_2_pwm(p2), .motor_3_pwm(p3), .motor_4_pwm(p4),
    .frame_sync(fs)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  // Drive the rates the next latch will see and queue the widths that frame must show.
  task automatic issue(input int f);
    int v[4];
    int dir[4];
    bit a;
    dir = '{128, 64, 1, 200};
    a = 1'b1;
    for (int c = 0; c < 4; c++)
      case (f)
        0: v[c] = 0;
        1: v[c] = 255;
        2: v[c] = dir[c];
        3, 4: v[c] = 200;
        default: case ($urandom_range(3))
          0: v[c] = 0;
          1: v[c] = 255;
          default: v[c] = int'($urandom_range(255));
        endcase
      endcase
`ifdef MOTOR_PWM_ARM_EN
    a = (f == 3) ? 1'b0 : (f < 5) ? 1'b1 : ($urandom_range(3) != 0);
    armed = a;
`endif
    r1 = 8'(v[0]); r2 = 8'(v[1]); r3 = 8'(v[2]); r4 = 8'(v[3]);
    for (int c = 0; c < 4; c++) exp_q.push_back(a ? MIN_W + v[c] * STEP : MIN_W);
  endtask

  // Entered just after a frame's latch negedge; each pass spans exactly one frame.
  task automatic run_frames(input int f0, input int n);
    int d;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? 3 : int'($urandom_range(FRAME - 1, 1));
      tick(d);
      issue(f0 + k + 1);
      tick(FRAME - d);
    end
  endtask

  int cur[4], hi[4], first[4], rises[4];
  int since = 0;
  bit have = 1'b0, rst_seen = 1'b0;
  logic [3:0] prev = '0;

  always @(negedge sys_clk) begin
    logic [3:0] pw;
    pw = {p4, p3, p2, p1};
    if (reset) begin
      have = 1'b0;
      rst_seen = 1'b1;
      prev = '0;
    end else begin
      since++;
      if (rst_seen) begin
        check("sync_after_reset", int'(fs), 1);
        rst_seen = 1'b0;
      end
      if (fs) begin
        if (have) begin
          check("frame_period", since, FRAME);
          for (int c = 0; c < 4; c++) begin
            check($sformatf("width_ch%0d", c + 1), hi[c], cur[c]);
            check($sformatf("rise_offset_ch%0d", c + 1), first[c], 1);
            check($sformatf("rise_count_ch%0d", c + 1), rises[c], 1);
          end
          frames_done++;
        end
        if (exp_q.size() < 4) begin
          check("expected_frame_queued", exp_q.size(), 4);
          have = 1'b0;
        end else begin
          for (int c = 0; c < 4; c++) cur[c] = exp_q.pop_front();
          have = 1'b1;
        end
        since = 0;
        for (int c = 0; c < 4; c++) begin
          hi[c] = 0; first[c] = -1; rises[c] = 0;
        end
      end else
        for (int c = 0; c < 4; c++)
          if (pw[c]) begin
            hi[c]++;
            if (!prev[c]) begin
              rises[c]++;
              first[c] = since;
            end
          end
      prev = pw;
    end
  end

  initial begin
    tick(3);
    check("reset_pwm", int'({p4, p3, p2, p1}), 0);
    check("reset_sync", int'(fs), 0);
    issue(0);
    reset = 1'b0;
    run_frames(0, NF1);
    tick(4);
    @(posedge sys_clk);
    #2;
    check("pre_reset_pwm_high", int'({p4, p3, p2, p1}), 15);
    reset = 1'b1;
    #1;
    check("async_reset_pwm", int'({p4, p3, p2, p1}), 0);
    check("async_reset_sync", int'(fs), 0);
    exp_q.delete();
    tick(3);
    issue(2);
    reset = 1'b0;
    run_frames(2, NF2);
    tick(2);
    check("frames_completed", frames_done, NF1 + NF2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
